sr_config_loader: RTL and testbench
===================================

Name: sr_config_loader

Overview:
- Sequences the 18-bit serial configuration shift register. Takes a parallel configuration word from the host logic and serialises it, LSB first.
- Clears the shift register first, then generates its shift clock and data: dt[4:0], signal-generator selectors, output/input/clock/PS selectors, ENABLE_OUTPUT.
- The shift register only accepts 18 bits after each reset, so this block pulses the shift register's reset at the start of every load. Reloads are therefore always clean.
- Sits between the host/config interface and the shift register's CLK_SR/RST/data_in pins.

Parameters:
- N_BITS, 18, number of configuration bits shifted per load.
- DIV, 4, system-clock cycles per SR_CLK half-period (>=1).
- RST_CYCLES, 2, system-clock cycles SR_RST is held high before shifting (>=1).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- cfg_word  in  N_BITS  configuration word; bit k lands in shift-register slot k.
- start  in  1  load request; accepted only in IDLE.
- abort  in  1  cancel an in-progress load.
- SR_CLK  out  1  shift clock to the shift register's CLK_SR.
- SR_DATA  out  1  serial data to the shift register's data_in.
- SR_RST  out  1  reset to the shift register's RST.
- busy  out  1  high from the cycle after start acceptance until load completes or aborts.
- done  out  1  one-cycle pulse on successful completion.
- aborted  out  1  one-cycle pulse when abort terminates a load.

Behaviour:
- All outputs are registered. On RST (sync): state=IDLE; SR_CLK=0, SR_DATA=0, SR_RST=0, busy=0, done=0, aborted=0; counters=0.
- States: IDLE, CLR, LOW, HIGH, FIN.
- IDLE, start=1: capture cfg_word into a shadow register. Next cycle: state=CLR, busy=1, SR_RST=1. start in any other state is ignored; the shadow is never updated mid-load.
- CLR: SR_RST=1 and SR_CLK=0 for RST_CYCLES cycles. Then SR_RST=0, bit index k=0, state=LOW.
- LOW: SR_CLK=0, SR_DATA=shadow[k] for DIV cycles. SR_DATA changes only on LOW entry, which gives DIV cycles of setup before the rising edge.
- HIGH: SR_CLK=1 for DIV cycles; SR_DATA is held, giving DIV cycles of hold. At exit:
  - k<N_BITS-1: k++, go to LOW.
  - otherwise: go to FIN.
- FIN: SR_CLK=0, SR_DATA=0, busy=0, done=1 for exactly one cycle; then IDLE.
- Latency: from the start-accept edge to the done cycle is 1 + RST_CYCLES + 2*DIV*N_BITS cycles (DIV=2, RST_CYCLES=2: 75). Exactly N_BITS rising SR_CLK edges per load.
- abort=1 in CLR/LOW/HIGH: next cycle SR_CLK=0, SR_DATA=0, SR_RST=1 for one cycle (partial data must not stay live), busy=0, aborted=1; then IDLE. abort in IDLE/FIN is ignored.
- abort has priority over phase-counter expiry in the same cycle.
- start and abort together in IDLE: start wins.
- RST mid-load: immediate return to reset values. SR_RST is not asserted by RST itself; the next load's CLR phase clears the shift register.
- SR_CLK and SR_RST are glitch-free single-flop outputs; never both high.
- Counter widths: phase counter $clog2(max(DIV,RST_CYCLES))+1; bit index $clog2(N_BITS).

Decomposition:
- Package sr_cfg_pkg:
  - constant N_BITS=18.
  - state enum.
  - field localparams for cfg_word: DT lsb 0 width 5; SEL_GEN1 5/2; SEL_GEN2 7/2; OUT_SEL_EXT 9/4; INPUT_SEL 13; CLK_SEL 14; PS_SEL 15; PS3_SEL 16; ENABLE_OUTPUT 17.
- One sub-module, sr_phase_timer: loadable down-counter with a terminal-count flag, reused for the CLR and LOW/HIGH durations.

Test Plan:
- Basic load (DIV=2, RST_CYCLES=2), cfg_word=18'h2A5A5, start pulse:
  - SR_RST high 2 cycles, then 18 SR_CLK rising edges.
  - SR_DATA at edge k equals bit k of 18'h2A5A5.
  - done 75 cycles after accept.
  - Shift-register model data_out=18'h2A5A5.
- Busy lockout: start with 18'h3FFFF, then start with 18'h00000 at cycle 10 → second start ignored, model ends at 18'h3FFFF, exactly one done.
- Reload: load 18'h3FFFF, then after done load 18'h00001 → SR_RST pulse precedes shifting, model ends at 18'h00001 (not saturated old data).
- Abort at cycle 30 of a load → next cycle SR_CLK=0, SR_RST=1 for 1 cycle, aborted=1, busy=0, no done. A following full load of 18'h12345 completes correctly.
- RST asserted at cycle 20 mid-load → all outputs 0 on the next edge, state IDLE. A subsequent load of 18'h0F0F0 gives the model value 18'h0F0F0.
- DIV=1, RST_CYCLES=1 → SR_CLK toggles every cycle, 18 edges, done 1+1+36=38 cycles after accept.

Source files
------------

// File: rtl/sr_cfg_pkg.sv
// Shared definitions for the serial configuration shift-register loader:
// word size, FSM states and the bit-field layout of the configuration word.
package sr_cfg_pkg;

    localparam int N_BITS = 18;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOW,
        HIGH,
        FIN
    } state_t;

    // Field layout of cfg_word (bit k lands in shift-register slot k)
    localparam int DT_LSB            = 0;
    localparam int DT_W              = 5;
    localparam int SEL_GEN1_LSB      = 5;
    localparam int SEL_GEN1_W        = 2;
    localparam int SEL_GEN2_LSB      = 7;
    localparam int SEL_GEN2_W        = 2;
    localparam int OUT_SEL_EXT_LSB   = 9;
    localparam int OUT_SEL_EXT_W     = 4;
    localparam int INPUT_SEL_BIT     = 13;
    localparam int CLK_SEL_BIT       = 14;
    localparam int PS_SEL_BIT        = 15;
    localparam int PS3_SEL_BIT       = 16;
    localparam int ENABLE_OUTPUT_BIT = 17;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_config_loader_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero, so loading
// L-1 makes a phase last exactly L cycles.
module sr_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/sr_config_loader.sv
// Clears the external configuration shift register, then shifts a captured
// configuration word into it LSB first using a divided, registered shift clock.
module sr_config_loader
    import sr_cfg_pkg::*;
#(
    parameter int N_BITS     = sr_cfg_pkg::N_BITS,
    parameter int DIV        = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_BITS-1:0] cfg_word,
    input  logic              start,
    input  logic              abort,
    output logic              SR_CLK,
    output logic              SR_DATA,
    output logic              SR_RST,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    localparam int TMR_W = $clog2(max_int(DIV, RST_CYCLES)) + 1;
    localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(DIV - 1);
    localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(RST_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(N_BITS - 1);

    state_t            state_q, state_d;
    logic [N_BITS-1:0] shadow_q, shadow_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              sr_clk_q, sr_clk_d;
    logic              sr_data_q, sr_data_d;
    logic              sr_rst_q, sr_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_tc;
    logic [BIT_W-1:0]  bit_nxt;

    sr_phase_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk     (CLK),
        .srst    (RST),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tc      (tmr_tc)
    );

    assign bit_nxt = bit_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        bit_d     = bit_q;
        sr_clk_d  = sr_clk_q;
        sr_data_d = sr_data_q;
        sr_rst_d  = sr_rst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        case (state_q)
            IDLE: begin
                // Also retires the one-cycle SR_RST pulse left by an abort
                sr_clk_d  = 1'b0;
                sr_data_d = 1'b0;
                sr_rst_d  = 1'b0;
                busy_d    = 1'b0;
                if (start) begin
                    shadow_d = cfg_word;
                    state_d  = CLR;
                    busy_d   = 1'b1;
                    sr_rst_d = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LOAD;
                end
            end
            CLR, LOW, HIGH: begin
                if (abort) begin
                    state_d   = IDLE;
                    sr_clk_d  = 1'b0;
                    sr_data_d = 1'b0;
                    sr_rst_d  = 1'b1;
                    busy_d    = 1'b0;
                    aborted_d = 1'b1;
                end else if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = DIV_LOAD;
                    if (state_q == CLR) begin
                        state_d   = LOW;
                        sr_rst_d  = 1'b0;
                        bit_d     = '0;
                        sr_data_d = shadow_q[0];
                    end else if (state_q == LOW) begin
                        state_d  = HIGH;
                        sr_clk_d = 1'b1;
                    end else begin
                        sr_clk_d = 1'b0;
                        if (bit_q < LAST_BIT) begin
                            state_d   = LOW;
                            bit_d     = bit_nxt;
                            sr_data_d = shadow_q[bit_nxt];
                        end else begin
                            state_d   = FIN;
                            sr_data_d = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            bit_q     <= '0;
            sr_clk_q  <= 1'b0;
            sr_data_q <= 1'b0;
            sr_rst_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_q     <= bit_d;
            sr_clk_q  <= sr_clk_d;
            sr_data_q <= sr_data_d;
            sr_rst_q  <= sr_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign SR_CLK  = sr_clk_q;
    assign SR_DATA = sr_data_q;
    assign SR_RST  = sr_rst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_sr_config_loader.sv
// Directed bench: two loaders (DIV=2/RST_CYCLES=2 and DIV=1/RST_CYCLES=1) each
// driving a behavioural 18-bit shift register that only accepts 18 bits per reset.
module tb_sr_config_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] cfg_a = '0, cfg_b = '0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        abort_a = 1'b0, abort_b = 1'b0;
    logic        sr_clk_a, sr_data_a, sr_rst_a, busy_a, done_a, aborted_a;
    logic        sr_clk_b, sr_data_b, sr_rst_b, busy_b, done_b, aborted_b;

    int n_total = 0;
    int n_bad   = 0;
    int idx     = 0;

    always #5 clk = ~clk;

    sr_config_loader #(.N_BITS(18), .DIV(2), .RST_CYCLES(2)) dut_a (
        .CLK(clk), .RST(rst), .cfg_word(cfg_a), .start(start_a), .abort(abort_a),
        .SR_CLK(sr_clk_a), .SR_DATA(sr_data_a), .SR_RST(sr_rst_a),
        .busy(busy_a), .done(done_a), .aborted(aborted_a)
    );

    sr_config_loader #(.N_BITS(18), .DIV(1), .RST_CYCLES(1)) dut_b (
        .CLK(clk), .RST(rst), .cfg_word(cfg_b), .start(start_b), .abort(abort_b),
        .SR_CLK(sr_clk_b), .SR_DATA(sr_data_b), .SR_RST(sr_rst_b),
        .busy(busy_b), .done(done_b), .aborted(aborted_b)
    );

    // Shift-register models: RST clears, then up to 18 bits shift in toward slot 0
    logic [17:0] model_a = '0, model_b = '0;
    int acc_a = 0, acc_b = 0;
    logic prev_a = 1'b0, prev_b = 1'b0;
    int edges_a = 0, edges_b = 0, rstcyc_a = 0, rstcyc_b = 0;
    int dones_a = 0, dones_b = 0, both_a = 0, both_b = 0;

    always @(posedge clk) begin
        prev_a <= sr_clk_a;
        if (sr_rst_a) begin
            model_a <= '0;
            acc_a   <= 0;
        end else if (sr_clk_a && !prev_a && acc_a < 18) begin
            model_a <= {sr_data_a, model_a[17:1]};
            acc_a   <= acc_a + 1;
        end
        if (sr_clk_a && !prev_a) edges_a <= edges_a + 1;
        if (sr_rst_a) rstcyc_a <= rstcyc_a + 1;
        if (done_a) dones_a <= dones_a + 1;
        if (sr_clk_a && sr_rst_a) both_a <= both_a + 1;
    end

    always @(posedge clk) begin
        prev_b <= sr_clk_b;
        if (sr_rst_b) begin
            model_b <= '0;
            acc_b   <= 0;
        end else if (sr_clk_b && !prev_b && acc_b < 18) begin
            model_b <= {sr_data_b, model_b[17:1]};
            acc_b   <= acc_b + 1;
        end
        if (sr_clk_b && !prev_b) edges_b <= edges_b + 1;
        if (sr_rst_b) rstcyc_b <= rstcyc_b + 1;
        if (done_b) dones_b <= dones_b + 1;
        if (sr_clk_b && sr_rst_b) both_b <= both_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // idx counts negedges after the accept edge (1 = first cycle after accept)
    task automatic step();
        @(negedge clk);
        idx++;
    endtask

    task automatic kick_a(input logic [17:0] w);
        @(negedge clk);
        cfg_a   = w;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        idx     = 1;
    endtask

    task automatic wait_done_a(input string tag);
        while (!done_a && idx < 300) step();
        chk(tag, {31'd0, done_a}, 32'd1);
    endtask

    int e0, r0, d0;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_sr_clk", {31'd0, sr_clk_a}, 32'd0);
        chk("reset_sr_rst", {31'd0, sr_rst_a}, 32'd0);
        chk("reset_busy", {31'd0, busy_a}, 32'd0);
        chk("reset_flags", {29'd0, sr_data_a, done_a, aborted_a}, 32'd0);

        // Basic load
        e0 = edges_a; r0 = rstcyc_a; d0 = dones_a;
        kick_a(18'h2A5A5);
        chk("basic_busy_first", {31'd0, busy_a}, 32'd1);
        chk("basic_rst_first", {30'd0, sr_rst_a, sr_clk_a}, 32'd2);
        wait_done_a("basic_done_seen");
        chk("basic_latency", idx, 75);
        chk("basic_busy_at_done", {31'd0, busy_a}, 32'd0);
        step();
        chk("basic_done_pulse", {31'd0, done_a}, 32'd0);
        chk("basic_model", {14'd0, model_a}, 32'h2A5A5);
        chk("basic_edges", edges_a - e0, 18);
        chk("basic_rst_cycles", rstcyc_a - r0, 2);

        // Busy lockout
        d0 = dones_a;
        kick_a(18'h3FFFF);
        while (idx < 10) step();
        cfg_a = 18'h00000; start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_done_a("lock_done_seen");
        repeat (90) step();
        chk("lock_model", {14'd0, model_a}, 32'h3FFFF);
        chk("lock_done_count", dones_a - d0, 1);

        // Reload after a full word of ones
        e0 = edges_a; r0 = rstcyc_a;
        kick_a(18'h00001);
        wait_done_a("reload_done_seen");
        step();
        chk("reload_model", {14'd0, model_a}, 32'h00001);
        chk("reload_rst_cycles", rstcyc_a - r0, 2);
        chk("reload_edges", edges_a - e0, 18);

        // Abort mid-load
        d0 = dones_a;
        kick_a(18'h2A5A5);
        while (idx < 30) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("abort_outputs", {26'd0, sr_clk_a, sr_data_a, sr_rst_a, busy_a, done_a, aborted_a}, 32'b001001);
        step();
        chk("abort_after", {29'd0, sr_rst_a, busy_a, aborted_a}, 32'd0);
        repeat (80) step();
        chk("abort_no_done", dones_a - d0, 0);
        kick_a(18'h12345);
        wait_done_a("abort_reload_done");
        step();
        chk("abort_reload_model", {14'd0, model_a}, 32'h12345);

        // RST mid-load
        d0 = dones_a;
        kick_a(18'h3C3C3);
        while (idx < 20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_outputs", {26'd0, sr_clk_a, sr_data_a, sr_rst_a, busy_a, done_a, aborted_a}, 32'd0);
        repeat (80) step();
        chk("rst_mid_no_done", dones_a - d0, 0);
        kick_a(18'h0F0F0);
        wait_done_a("rst_reload_done");
        step();
        chk("rst_reload_model", {14'd0, model_a}, 32'h0F0F0);

        // DIV=1, RST_CYCLES=1 instance; abort with start in IDLE must not block it
        e0 = edges_b; r0 = rstcyc_b;
        @(negedge clk);
        cfg_b = 18'h2A5A5; start_b = 1'b1; abort_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; abort_b = 1'b0; idx = 1;
        chk("b_clr", {30'd0, sr_rst_b, sr_clk_b}, 32'd2);
        step();
        chk("b_low0", {30'd0, sr_rst_b, sr_clk_b}, 32'd0);
        step();
        chk("b_high0", {31'd0, sr_clk_b}, 32'd1);
        step();
        chk("b_low1", {31'd0, sr_clk_b}, 32'd0);
        while (!done_b && idx < 300) step();
        chk("b_done_seen", {31'd0, done_b}, 32'd1);
        chk("b_latency", idx, 38);
        step();
        chk("b_model", {14'd0, model_b}, 32'h2A5A5);
        chk("b_edges", edges_b - e0, 18);
        chk("b_rst_cycles", rstcyc_b - r0, 1);

        chk("never_clk_and_rst", both_a + both_b, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
